key_event_debouncer: RTL and testbench
======================================

KEY_EVENT_DEBOUNCER -- requirements
Module: key_event_debouncer

Interface
REQ-001 Parameter WIDTH, default 4: key code width in bits.
REQ-002 Parameter IDLE_CODE, default {WIDTH{1'b1}}: code meaning "no key pressed".
REQ-003 Parameter STABLE_SCANS, default 3, legal range >=2: consecutive equal scans needed to accept a press or a release.
REQ-004 Parameter REPEAT_DELAY, default 4, legal range >=1: scans from press acceptance to the first auto-repeat event.
REQ-005 Parameter REPEAT_RATE, default 2, legal range >=1: scans between later auto-repeat events.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two >=2: event queue entries.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 scan_en  in  1  one-cycle strobe; key_in is sampled only on cycles where it is high.
REQ-010 key_in  in  WIDTH  raw scanned key code; IDLE_CODE means no key.
REQ-011 repeat_en  in  1  enables auto-repeat events while a key is held.
REQ-012 key_value  out  WIDTH  debounced current key; IDLE_CODE when no key is held.
REQ-013 key_held  out  1  high while state is PRESSED or RELCHK.
REQ-014 ev_valid  out  1  event queue not empty.
REQ-015 ev_code  out  WIDTH  code at the queue head; valid only while ev_valid is high.
REQ-016 ev_ready  in  1  consumer accept; pop occurs when ev_valid and ev_ready are both high.
REQ-017 ev_count  out  clog2(FIFO_DEPTH)+1  current number of queued events.
REQ-018 ev_overflow  out  1  one-cycle pulse when an event is dropped.

Function
REQ-019 The FSM SHALL have four states: IDLE, CAND, PRESSED and RELCHK; it advances only on scan_en cycles.
REQ-020 IDLE: on a scan with key_in!=IDLE_CODE, cand<=key_in, cnt<=1, go to CAND.
REQ-021 CAND, scan with key_in==cand: cnt increments; when the count reaches STABLE_SCANS, go to PRESSED, key_value<=cand, push a press event, rep<=0.
REQ-022 CAND, scan with key_in==IDLE_CODE: go to IDLE.
REQ-023 CAND, scan with a different non-idle code: cand<=key_in, cnt<=1, stay in CAND.
REQ-024 PRESSED, scan with key_in!=cand: go to RELCHK with cnt<=1.
REQ-025 RELCHK, scan with key_in==cand: return to PRESSED; the repeat counter is preserved.
REQ-026 RELCHK, scan with key_in!=cand: cnt increments; when the count reaches STABLE_SCANS, go to IDLE and key_value<=IDLE_CODE.
REQ-027 A new key pressed during RELCHK SHALL be picked up only from IDLE, on a later scan.
REQ-028 Auto-repeat: in PRESSED with repeat_en=1, rep increments each scan.
REQ-029 When rep reaches REPEAT_DELAY, push event cand; thereafter push event cand every REPEAT_RATE scans.
REQ-030 repeat_en=0 clears rep to 0; rep also holds while in RELCHK.
REQ-031 Release SHALL generate no event.
REQ-032 Push latency: the event is written at the clock edge of the qualifying scan; ev_valid and ev_count reflect it in the following cycle.
REQ-033 The FIFO SHALL be first-in first-out; ev_code SHALL be stable while ev_valid=1 and no pop occurs.
REQ-034 Push when full with no pop: the event is dropped, ev_overflow=1 for one cycle, and queue contents are unchanged.
REQ-035 Simultaneous push and pop when full: both occur, ev_count is unchanged, and there is no overflow.
REQ-036 Simultaneous push and pop when empty: the push is stored and the pop is ignored, since ev_valid=0.
REQ-037 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-038 Cycles without scan_en SHALL change no FSM state or counters, but FIFO pops still occur.

Reset
REQ-039 rst=1 at a clock edge SHALL set state=IDLE, cnt=0, rep=0, cand=IDLE_CODE, key_value=IDLE_CODE, key_held=0, FIFO empty (ev_valid=0, ev_count=0) and ev_overflow=0.
REQ-040 Reset SHALL dominate scan_en, ev_ready and any pending push, and SHALL act identically from any state, including mid-CAND or mid-RELCHK.

Verification (WIDTH=4, STABLE_SCANS=3, REPEAT_DELAY=4, REPEAT_RATE=2, FIFO_DEPTH=4, ev_ready=1 unless stated)
REQ-041 Scans key_in 5,5,5 then F,F,F -> key_value=5 after the 3rd scan, exactly one event with code 5, and key_value=F after the 6th scan with no further event.
REQ-042 Bounce: scans 5,F,5,5,5 -> key_value stays F through the 4th scan and becomes 5 after the 5th; a single event with code 5.
REQ-043 Change: scans 5,5,7,7,7 -> no event for 5; key_value=7 after the 5th scan; exactly one event with code 7.
REQ-044 repeat_en=1, key 9 held 8 scans past acceptance -> events with code 9 at acceptance and at scans +4, +6 and +8 (4 total); a single F glitch mid-hold produces no extra event.
REQ-045 ev_ready=0, five accepted presses 1,2,3,4,5 -> ev_count=4, ev_overflow pulses on the 5th, and ev_code=1. Then: with ev_ready=1 on the same cycle as a sixth push (full) -> ev_count stays 4 and there is no overflow.
REQ-046 rst pulsed while in PRESSED with 2 events queued -> next cycle key_value=F, key_held=0, ev_valid=0, ev_count=0.

Source files
------------

// File: rtl/key_event_debouncer_if.sv
// Scanner/consumer bundle for the key event debouncer.
// The slave side is the debouncer itself; the master side drives scans and consumes events.
interface key_event_debouncer_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  logic              scan_en;
  logic [WIDTH-1:0]  key_in;
  logic              repeat_en;
  logic [WIDTH-1:0]  key_value;
  logic              key_held;
  logic              ev_valid;
  logic [WIDTH-1:0]  ev_code;
  logic              ev_ready;
  logic [CountW-1:0] ev_count;
  logic              ev_overflow;

  // Scanner plus event consumer.
  modport master (
    output scan_en,
    output key_in,
    output repeat_en,
    output ev_ready,
    input  key_value,
    input  key_held,
    input  ev_valid,
    input  ev_code,
    input  ev_count,
    input  ev_overflow
  );

  // Debouncer.
  modport slave (
    input  scan_en,
    input  key_in,
    input  repeat_en,
    input  ev_ready,
    output key_value,
    output key_held,
    output ev_valid,
    output ev_code,
    output ev_count,
    output ev_overflow
  );
endinterface

// File: rtl/key_event_debouncer.sv
// Debounces a scanned key code, emits press and auto-repeat events into a small FIFO.
// Release is debounced too but produces no event.
module key_event_debouncer #(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] IDLE_CODE    = {WIDTH{1'b1}},
  parameter int unsigned      STABLE_SCANS = 3,
  parameter int unsigned      REPEAT_DELAY = 4,
  parameter int unsigned      REPEAT_RATE  = 2,
  parameter int unsigned      FIFO_DEPTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  key_event_debouncer_if.slave bus
);

  localparam int unsigned CntW   = $clog2(STABLE_SCANS + 1);
  localparam int unsigned RepW   = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CntW-1:0]   StableLast = CntW'(STABLE_SCANS);
  localparam logic [RepW-1:0]   RepDelay   = RepW'(REPEAT_DELAY);
  // Reaching Delay+Rate re-arms the counter at Delay, so it never grows past this bound.
  localparam logic [RepW-1:0]   RepWrap    = RepW'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [CountW-1:0] CountFull  = CountW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StCand,
    StPressed,
    StRelchk
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [RepW-1:0]  rep_q, rep_d, rep_inc;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] key_value_q, key_value_d;
  logic             key_match;
  logic             key_idle;
  logic             push;
  logic [WIDTH-1:0] push_code;

  logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              wr_en;

  // Decode the incoming scan against the current candidate.
  always_comb begin
    key_match = (bus.key_in == cand_q);
    key_idle  = (bus.key_in == IDLE_CODE);
    cnt_inc   = cnt_q + CntW'(1);
    rep_inc   = rep_q + RepW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; only scan cycles may move the state.
  always_comb begin
    state_d = state_q;
    if (bus.scan_en) begin
      case (state_q)
        StIdle: begin
          if (!key_idle) state_d = StCand;
        end
        StCand: begin
          if (key_match) begin
            if (cnt_inc == StableLast) state_d = StPressed;
          end else if (key_idle) begin
            state_d = StIdle;
          end
        end
        StPressed: begin
          if (!key_match) state_d = StRelchk;
        end
        StRelchk: begin
          if (key_match) begin
            state_d = StPressed;
          end else if (cnt_inc == StableLast) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Counters, candidate, debounced value and event generation for the current scan.
  always_comb begin
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    cand_d      = cand_q;
    key_value_d = key_value_q;
    push        = 1'b0;
    push_code   = cand_q;
    if (bus.scan_en) begin
      case (state_q)
        StIdle: begin
          if (!key_idle) begin
            cand_d = bus.key_in;
            cnt_d  = CntW'(1);
          end
        end
        StCand: begin
          if (key_match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == StableLast) begin
              key_value_d = cand_q;
              rep_d       = '0;
              push        = 1'b1;
            end
          end else if (!key_idle) begin
            cand_d = bus.key_in;
            cnt_d  = CntW'(1);
          end
        end
        StPressed: begin
          if (!key_match) begin
            cnt_d = CntW'(1);
          end else if (!bus.repeat_en) begin
            rep_d = '0;
          end else begin
            rep_d = rep_inc;
            if (rep_inc == RepDelay) begin
              push = 1'b1;
            end else if (rep_inc == RepWrap) begin
              push  = 1'b1;
              rep_d = RepDelay;
            end
          end
        end
        StRelchk: begin
          // Any code other than the held one counts towards release; a new key is only
          // considered once back in idle.
          if (!key_match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == StableLast) key_value_d = IDLE_CODE;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rep_q       <= '0;
      cand_q      <= IDLE_CODE;
      key_value_q <= IDLE_CODE;
    end else begin
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      cand_q      <= cand_d;
      key_value_q <= key_value_d;
    end
  end

  // FIFO control: a pop on a full queue makes room for a same-cycle push.
  always_comb begin
    fifo_full  = (count_q == CountFull);
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty && bus.ev_ready;
    wr_en      = push && (!fifo_full || pop);
    ovf_d      = push && fifo_full && !pop;
    wr_ptr_d   = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  // FSM and queue outputs.
  always_comb begin
    bus.key_value   = key_value_q;
    bus.key_held    = (state_q == StPressed) || (state_q == StRelchk);
    bus.ev_valid    = !fifo_empty;
    bus.ev_code     = mem_q[rd_ptr_q];
    bus.ev_count    = count_q;
    bus.ev_overflow = ovf_q;
  end

endmodule

// File: tb/tb_key_event_debouncer.sv
// Directed bench for key_event_debouncer with a per-cycle reference model.
module tb_key_event_debouncer;

  localparam int unsigned W      = 4;
  localparam int unsigned STABLE = 3;
  localparam int unsigned DELAY  = 4;
  localparam int unsigned RATE   = 2;
  localparam int unsigned DEPTH  = 4;
  localparam logic [W-1:0] IDLE  = 4'hF;

  localparam int MIdle    = 0;
  localparam int MCand    = 1;
  localparam int MHeld    = 2;
  localparam int MRelease = 3;

  logic clk = 1'b0;
  logic rst;

  key_event_debouncer_if #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) bus ();

  key_event_debouncer #(
    .WIDTH       (W),
    .IDLE_CODE   (IDLE),
    .STABLE_SCANS(STABLE),
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: spec rules with unbounded counters and a queue.
  bit           m_live = 1'b0;
  int           m_mode = MIdle;
  logic [W-1:0] m_cand = IDLE;
  logic [W-1:0] m_kv   = IDLE;
  int           m_cnt  = 0;
  int           m_rep  = 0;
  bit           m_ovf  = 1'b0;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_popped[$];

  task automatic model_step();
    bit           push;
    bit           pop;
    bit           full;
    logic [W-1:0] k;
    if (rst) begin
      m_live = 1'b1;
      m_mode = MIdle;
      m_cand = IDLE;
      m_kv   = IDLE;
      m_cnt  = 0;
      m_rep  = 0;
      m_ovf  = 1'b0;
      m_q.delete();
      return;
    end
    if (!m_live) return;
    push = 1'b0;
    k    = bus.key_in;
    pop  = (m_q.size() != 0) && bus.ev_ready;
    if (bus.scan_en) begin
      case (m_mode)
        MIdle: if (k != IDLE) begin
          m_cand = k;
          m_cnt  = 1;
          m_mode = MCand;
        end
        MCand: begin
          if (k == m_cand) begin
            m_cnt++;
            if (m_cnt == STABLE) begin
              m_mode = MHeld;
              m_kv   = m_cand;
              m_rep  = 0;
              push   = 1'b1;
            end
          end else if (k == IDLE) begin
            m_mode = MIdle;
          end else begin
            m_cand = k;
            m_cnt  = 1;
          end
        end
        MHeld: begin
          if (k != m_cand) begin
            m_mode = MRelease;
            m_cnt  = 1;
          end else if (!bus.repeat_en) begin
            m_rep = 0;
          end else begin
            m_rep++;
            if (m_rep == DELAY || (m_rep > DELAY && (m_rep - DELAY) % RATE == 0)) push = 1'b1;
          end
        end
        default: begin
          if (k == m_cand) begin
            m_mode = MHeld;
          end else begin
            m_cnt++;
            if (m_cnt == STABLE) begin
              m_mode = MIdle;
              m_kv   = IDLE;
            end
          end
        end
      endcase
    end
    full  = (m_q.size() == DEPTH);
    m_ovf = push && full && !pop;
    if (pop) m_popped.push_back(m_q.pop_front());
    if (push && (!full || pop)) m_q.push_back(m_cand);
  endtask

  // Model update on each rising edge; DUT outputs compared shortly after.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (m_live) begin
        chk("key_value", 32'(bus.key_value), 32'(m_kv));
        chk("key_held", 32'(bus.key_held), 32'(m_mode == MHeld || m_mode == MRelease));
        chk("ev_valid", 32'(bus.ev_valid), 32'(m_q.size() != 0));
        chk("ev_count", 32'(bus.ev_count), 32'(m_q.size()));
        chk("ev_overflow", 32'(bus.ev_overflow), 32'(m_ovf));
        if (m_q.size() != 0) chk("ev_code", 32'(bus.ev_code), 32'(m_q[0]));
      end
    end
  end

  task automatic scan(input logic [W-1:0] k);
    @(negedge clk);
    bus.scan_en = 1'b1;
    bus.key_in  = k;
    @(negedge clk);
    bus.scan_en = 1'b0;
  endtask

  task automatic scan_n(input logic [W-1:0] k, input int n);
    for (int i = 0; i < n; i++) scan(k);
  endtask

  task automatic scan_rdy(input logic [W-1:0] k);
    @(negedge clk);
    bus.scan_en  = 1'b1;
    bus.key_in   = k;
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.scan_en  = 1'b0;
    bus.ev_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Reset asserted together with a scan and a consumer accept.
  task automatic rst_pulse(input logic [W-1:0] k);
    @(negedge clk);
    rst          = 1'b1;
    bus.scan_en  = 1'b1;
    bus.key_in   = k;
    bus.ev_ready = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.scan_en = 1'b0;
  endtask

  task automatic chk_popped(input string name, input logic [31:0] exp_n);
    chk({name, "_n"}, 32'(m_popped.size()), exp_n);
  endtask

  initial begin
    rst           = 1'b1;
    bus.scan_en   = 1'b0;
    bus.key_in    = IDLE;
    bus.repeat_en = 1'b0;
    bus.ev_ready  = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_key_value", 32'(bus.key_value), 32'hF);
    chk("rst_key_held", 32'(bus.key_held), 32'h0);
    chk("rst_ev_valid", 32'(bus.ev_valid), 32'h0);
    chk("rst_ev_count", 32'(bus.ev_count), 32'h0);

    // Clean press and release.
    m_popped.delete();
    scan_n(4'h5, 3);
    chk("press_kv", 32'(bus.key_value), 32'h5);
    chk("press_valid", 32'(bus.ev_valid), 32'h1);
    scan_n(IDLE, 3);
    chk("release_kv", 32'(bus.key_value), 32'hF);
    idle(2);
    chk_popped("press_ev", 1);
    if (m_popped.size() > 0) chk("press_code", 32'(m_popped[0]), 32'h5);

    // Bounce.
    m_popped.delete();
    scan(4'h5); scan(IDLE); scan(4'h5); scan(4'h5);
    chk("bounce_kv4", 32'(bus.key_value), 32'hF);
    scan(4'h5);
    chk("bounce_kv5", 32'(bus.key_value), 32'h5);
    scan_n(IDLE, 3);
    idle(2);
    chk_popped("bounce_ev", 1);
    if (m_popped.size() > 0) chk("bounce_code", 32'(m_popped[0]), 32'h5);

    // Candidate change.
    m_popped.delete();
    scan(4'h5); scan(4'h5); scan(4'h7); scan(4'h7);
    chk("change_kv4", 32'(bus.key_value), 32'hF);
    scan(4'h7);
    chk("change_kv5", 32'(bus.key_value), 32'h7);
    scan_n(IDLE, 3);
    idle(2);
    chk_popped("change_ev", 1);
    if (m_popped.size() > 0) chk("change_code", 32'(m_popped[0]), 32'h7);

    // Auto-repeat: acceptance plus holds at +4, +6, +8.
    m_popped.delete();
    bus.repeat_en = 1'b1;
    scan_n(4'h9, 3);
    scan_n(4'h9, 8);
    idle(2);
    chk_popped("repeat_ev", 4);
    for (int i = 0; i < m_popped.size(); i++) chk("repeat_code", 32'(m_popped[i]), 32'h9);
    scan_n(IDLE, 3);
    idle(2);
    chk_popped("repeat_rel_ev", 4);

    // Glitch mid-hold holds the repeat counter without adding an event.
    m_popped.delete();
    scan_n(4'h9, 3);
    scan_n(4'h9, 3);
    scan(IDLE);
    scan(4'h9);
    idle(2);
    chk_popped("glitch_ev", 1);
    chk("glitch_held", 32'(bus.key_held), 32'h1);
    scan(4'h9);
    idle(2);
    chk_popped("glitch_rep_ev", 2);
    bus.repeat_en = 1'b0;
    scan_n(IDLE, 3);

    // Overflow with the consumer stalled.
    idle(2);
    m_popped.delete();
    bus.ev_ready = 1'b0;
    for (int p = 1; p <= 4; p++) begin
      scan_n(4'(p), 3);
      scan_n(IDLE, 3);
    end
    scan_n(4'h5, 3);
    chk("ovf_pulse", 32'(bus.ev_overflow), 32'h1);
    chk("ovf_count", 32'(bus.ev_count), 32'h4);
    chk("ovf_code", 32'(bus.ev_code), 32'h1);
    idle(1);
    chk("ovf_clear", 32'(bus.ev_overflow), 32'h0);
    scan_n(IDLE, 3);
    scan_n(4'h6, 2);
    scan_rdy(4'h6);
    chk("fullpp_count", 32'(bus.ev_count), 32'h4);
    chk("fullpp_ovf", 32'(bus.ev_overflow), 32'h0);
    chk("fullpp_code", 32'(bus.ev_code), 32'h2);
    scan_n(IDLE, 3);
    bus.ev_ready = 1'b1;
    idle(6);
    chk_popped("drain_ev", 5);
    if (m_popped.size() == 5) begin
      chk("drain0", 32'(m_popped[0]), 32'h1);
      chk("drain1", 32'(m_popped[1]), 32'h2);
      chk("drain2", 32'(m_popped[2]), 32'h3);
      chk("drain3", 32'(m_popped[3]), 32'h4);
      chk("drain4", 32'(m_popped[4]), 32'h6);
    end

    // Reset while pressed with two events queued.
    bus.ev_ready = 1'b0;
    scan_n(4'h1, 3);
    scan_n(IDLE, 3);
    scan_n(4'h2, 3);
    chk("prerst_count", 32'(bus.ev_count), 32'h2);
    rst_pulse(4'h2);
    chk("rst_pr_kv", 32'(bus.key_value), 32'hF);
    chk("rst_pr_held", 32'(bus.key_held), 32'h0);
    chk("rst_pr_valid", 32'(bus.ev_valid), 32'h0);
    chk("rst_pr_count", 32'(bus.ev_count), 32'h0);
    bus.ev_ready = 1'b1;

    // Reset mid-candidate restarts the count.
    scan_n(4'h3, 2);
    rst_pulse(4'h3);
    scan_n(4'h3, 2);
    chk("rst_cand_kv", 32'(bus.key_value), 32'hF);
    scan(4'h3);
    chk("rst_cand_kv3", 32'(bus.key_value), 32'h3);

    // Reset mid-release, then a new key needs a full debounce.
    scan_n(IDLE, 2);
    rst_pulse(IDLE);
    chk("rst_rel_held", 32'(bus.key_held), 32'h0);
    scan_n(4'hA, 2);
    chk("rst_rel_kv", 32'(bus.key_value), 32'hF);
    scan(4'hA);
    chk("rst_rel_kvA", 32'(bus.key_value), 32'hA);
    scan_n(IDLE, 3);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
